// File: rtl/gate_pkg.sv
// Shared types and default constants for the crossing gate sequencer.
// Holds the FSM state enum and a small constant helper.
package gate_pkg;

    typedef enum logic [2:0] {
        GS_OPEN,
        GS_WARN,
        GS_CLOSING,
        GS_CLOSED,
        GS_HOLD,
        GS_OPENING
    } gs_state_t;

    localparam int STEPS_TRAVEL_DEF = 512;
    localparam int WARN_TICKS_DEF   = 8;
    localparam int CLEAR_TICKS_DEF  = 16;
    localparam int OCC_W_DEF        = 3;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gate_sequencer_if.sv
// Sensor, tick and motor/lamp bundle between the track side and the sequencer.
// The master drives the sensors and tick; the slave drives motor and status.
interface gate_sequencer_if;

    logic step_tick;
    logic train_in;
    logic train_out;
    logic motor_step;
    logic motor_dir;
    logic warn_lamp;
    logic gate_closed;
    logic gate_open;
    logic sensor_err;

    modport master (
        output step_tick, train_in, train_out,
        input  motor_step, motor_dir, warn_lamp,
        input  gate_closed, gate_open, sensor_err
    );

    modport slave (
        input  step_tick, train_in, train_out,
        output motor_step, motor_dir, warn_lamp,
        output gate_closed, gate_open, sensor_err
    );

endinterface

// File: rtl/gate_sequencer_train_counter.sv
// Rising-edge detectors on both track sensors feeding a saturating
// occupancy counter, with a sticky flag for departures from an empty section.
module train_counter
    import gate_pkg::*;
#(
    parameter int OCC_W = OCC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             train_in,
    input  logic             train_out,
    output logic [OCC_W-1:0] occ,
    output logic             sensor_err
);

    localparam logic [OCC_W-1:0] OCC_MAX = '1;

    logic in_q;
    logic out_q;
    logic rise_in;
    logic rise_out;

    assign rise_in  = train_in & ~in_q;
    assign rise_out = train_out & ~out_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q       <= 1'b0;
            out_q      <= 1'b0;
            occ        <= '0;
            sensor_err <= 1'b0;
        end else begin
            in_q  <= train_in;
            out_q <= train_out;
            // simultaneous edges cancel out
            unique case (1'b1)
                rise_in && !rise_out: begin
                    if (occ != OCC_MAX) occ <= occ + 1'b1;
                end
                rise_out && !rise_in: begin
                    if (occ == '0) sensor_err <= 1'b1;
                    else           occ <= occ - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/gate_sequencer.sv
// Crossing gate FSM: warning lamp, stepper direction/step pulses and
// absolute gate position, with mid-travel reversal while opening.
module gate_sequencer
    import gate_pkg::*;
#(
    parameter int STEPS_TRAVEL = STEPS_TRAVEL_DEF,
    parameter int WARN_TICKS   = WARN_TICKS_DEF,
    parameter int CLEAR_TICKS  = CLEAR_TICKS_DEF,
    parameter int OCC_W        = OCC_W_DEF
) (
    input logic             clk,
    input logic             rst_n,
    gate_sequencer_if.slave bus
);

    localparam int PW = $clog2(STEPS_TRAVEL + 1);
    localparam int TW = $clog2(max2(WARN_TICKS, CLEAR_TICKS) + 1);

    localparam logic [PW-1:0] POS_MAX   = PW'(STEPS_TRAVEL);
    localparam logic [PW-1:0] POS_ONE   = PW'(1);
    localparam logic [TW-1:0] WARN_END  = TW'(WARN_TICKS);
    localparam logic [TW-1:0] CLEAR_END = TW'(CLEAR_TICKS);

    gs_state_t        state;
    logic [PW-1:0]    pos;
    logic [TW-1:0]    tcnt;
    logic [OCC_W-1:0] occ;
    logic             busy;
    logic             tick;
    logic             step;
    logic             dir;
    logic             lamp;
    logic             closed;
    logic             open;

    assign busy = (occ != '0);
    assign tick = bus.step_tick;

    assign bus.motor_step  = step;
    assign bus.motor_dir   = dir;
    assign bus.warn_lamp   = lamp;
    assign bus.gate_closed = closed;
    assign bus.gate_open   = open;

    train_counter #(.OCC_W(OCC_W)) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .train_in   (bus.train_in),
        .train_out  (bus.train_out),
        .occ        (occ),
        .sensor_err (bus.sensor_err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= GS_OPEN;
            pos    <= '0;
            tcnt   <= '0;
            step   <= 1'b0;
            dir    <= 1'b0;
            lamp   <= 1'b0;
            closed <= 1'b0;
            open   <= 1'b1;
        end else begin
            step <= 1'b0;
            if (state != GS_OPEN && tick) lamp <= ~lamp;
            unique case (state)
                GS_OPEN: begin
                    if (busy) begin
                        state <= GS_WARN;
                        tcnt  <= '0;
                        lamp  <= 1'b1;
                        open  <= 1'b0;
                    end
                end
                GS_WARN: begin
                    if (tick) begin
                        tcnt <= tcnt + 1'b1;
                        if (tcnt + 1'b1 == WARN_END) state <= GS_CLOSING;
                    end
                end
                GS_CLOSING: begin
                    if (pos == POS_MAX) begin
                        state  <= GS_CLOSED;
                        closed <= 1'b1;
                    end else if (tick) begin
                        step <= 1'b1;
                        dir  <= 1'b1;
                        pos  <= pos + 1'b1;
                        if (pos + 1'b1 == POS_MAX) begin
                            state  <= GS_CLOSED;
                            closed <= 1'b1;
                        end
                    end
                end
                GS_CLOSED: begin
                    if (!busy) begin
                        state <= GS_HOLD;
                        tcnt  <= '0;
                    end
                end
                GS_HOLD: begin
                    if (busy) begin
                        state <= GS_CLOSED;
                    end else if (tick) begin
                        tcnt <= tcnt + 1'b1;
                        if (tcnt + 1'b1 == CLEAR_END) begin
                            state  <= GS_OPENING;
                            closed <= 1'b0;
                        end
                    end
                end
                GS_OPENING: begin
                    // a new train reverses now; the step waits for the next tick
                    if (busy) begin
                        state <= GS_CLOSING;
                    end else if (pos == '0) begin
                        state <= GS_OPEN;
                        open  <= 1'b1;
                        lamp  <= 1'b0;
                    end else if (tick) begin
                        step <= 1'b1;
                        dir  <= 1'b0;
                        pos  <= pos - 1'b1;
                        if (pos == POS_ONE) begin
                            state <= GS_OPEN;
                            open  <= 1'b1;
                            lamp  <= 1'b0;
                        end
                    end
                end
                default: state <= GS_OPEN;
            endcase
        end
    end

endmodule

// File: doc/gate_sequencer.md
# gate_sequencer

Controller for the railway crossing gate stepper: counts trains entering and leaving the protected section from two track sensors, runs the warning lamp, and commands the stepper phase driver with a direction and one step pulse per divided tick. It sits between the track sensors and the 4-phase coil driver, and tracks absolute gate position so that an opening gate can reverse mid-travel when a new train arrives.

## Interface
- `STEPS_TRAVEL`, 512: steps from fully open (pos 0) to fully closed (pos `STEPS_TRAVEL`).
- `WARN_TICKS`, 8: ticks of lamp-only warning before the gate starts closing.
- `CLEAR_TICKS`, 16: ticks the section must stay empty before the gate starts opening.
- `OCC_W`, 3: occupancy counter width.

Ports (one clock, `clk`; reset `rst_n` is synchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous active-low reset.
- `step_tick` in 1: one-`clk` enable pulse from the clock divider; the only pacing for motion and timers.
- `train_in` in 1: approach sensor, level, synchronous to `clk`.
- `train_out` in 1: departure sensor, level, synchronous to `clk`.
- `motor_step` out 1: one-cycle pulse; the phase driver advances one step.
- `motor_dir` out 1: 1 = closing, 0 = opening; valid whenever `motor_step` is high.
- `warn_lamp` out 1: flashing warning lamp.
- `gate_closed` out 1: gate at full travel and held.
- `gate_open` out 1: gate at pos 0 and idle.
- `sensor_err` out 1: sticky; a departure was seen with occupancy 0.

## Operation
- Sensor edge detect: a rising edge on `train_in` increments `occ`, and a rising edge on `train_out` decrements it. If both edges arrive in the same cycle, `occ` is unchanged. Increment saturates at 2^`OCC_W`−1. A decrement at 0 is ignored and sets `sensor_err`.
- Position counter `pos` runs from 0 to `STEPS_TRAVEL`. It changes only in a cycle where `motor_step`=1: +1 when closing, −1 when opening.
- States:
  - OPEN:
    - `occ`≠0 → WARN, with the tick counter cleared.
  - WARN:
    - Counts `step_tick`.
    - After `WARN_TICKS` ticks → CLOSING.
  - CLOSING:
    - Each `step_tick` issues a step with dir=1.
    - When `pos` reaches `STEPS_TRAVEL` → CLOSED.
  - CLOSED:
    - `occ`=0 → HOLD, with the tick counter cleared.
  - HOLD:
    - `occ`≠0 → CLOSED.
    - After `CLEAR_TICKS` ticks → OPENING.
  - OPENING:
    - Each `step_tick` issues a step with dir=0.
    - `occ`≠0 → CLOSING immediately from the current `pos`, with no WARN phase.
    - `pos`=0 → OPEN.
- `occ` returning to 0 during WARN or CLOSING does not abort closing. The gate always completes to CLOSED and then goes through HOLD.
- `warn_lamp` is 0 in OPEN. In every other state it toggles on each `step_tick`, and it is forced to 1 on entry to WARN.
- `gate_closed` = state ∈ {CLOSED, HOLD}. `gate_open` = state OPEN.

## Timing
- Reset values: state OPEN, `pos` 0, `occ` 0, `motor_step` 0, `motor_dir` 0, `warn_lamp` 0, `gate_closed` 0, `gate_open` 1, `sensor_err` 0.
- All outputs are registered.
- Sensor edge to `occ` update: 1 cycle. `occ` to state change: 1 further cycle.
- `motor_step` is asserted in the cycle after the qualifying `step_tick`, never for more than 1 cycle. `motor_dir` is stable in that cycle.
- The final step is issued in the same cycle the state leaves CLOSING/OPENING. No step is issued beyond `pos` limits.
- A reversal in OPENING takes effect on the next `step_tick` after the transition. Direction never changes within a `motor_step` cycle.
- Reset asserted mid-travel: reset values apply on the next edge, and `pos` is forced to 0. The gate is presumed to be at home after a power/reset cycle.
- `step_tick` held high continuously is legal: one step per `clk`.

## Structure
- Package `gate_pkg` contains:
  - the state enum (`GS_OPEN`, `GS_WARN`, `GS_CLOSING`, `GS_CLOSED`, `GS_HOLD`, `GS_OPENING`);
  - the default constants for `STEPS_TRAVEL`, `WARN_TICKS` and `CLEAR_TICKS`.
- One sub-module, `train_counter`, handles both sensor edge detectors, the saturating `occ` counter and `sensor_err`. The FSM, `pos` and timers live in `gate_sequencer`.
- The tick counter width is derived from max(`WARN_TICKS`, `CLEAR_TICKS`). The `pos` width is derived from `STEPS_TRAVEL`.

## Test plan
Parameters for all scenarios: `STEPS_TRAVEL`=4, `WARN_TICKS`=2, `CLEAR_TICKS`=3, `step_tick` every 4 `clk`.
- Single train: pulse `train_in`.
  - WARN lasts 2 ticks, then 4 `motor_step` pulses with dir=1, then `gate_closed`=1.
  - Pulse `train_out`: 3 ticks later, 4 steps with dir=0, then `gate_open`=1 and `warn_lamp`=0.
- Reversal: pulse `train_out` and let 2 opening steps complete (`pos`=2), then pulse `train_in`.
  - Next tick gives dir=1 steps, exactly 2, then CLOSED. No WARN phase.
- HOLD abort: pulse `train_in` during HOLD after 2 ticks.
  - Returns to CLOSED with no `motor_step`. A later `train_out` restarts the full 3-tick hold.
- Two trains, and simultaneous edges:
  - `train_in` twice, then one `train_out`: gate stays closed.
  - Second `train_out`: gate opens.
  - Simultaneous `train_in`/`train_out` edges leave `occ` unchanged.
- Error: `train_out` pulse at reset state.
  - `sensor_err`=1 and stays 1.
  - `occ`=0 and the gate stays open.
- Reset mid-CLOSING at `pos`=3: all outputs return to reset values on the next edge, and a following train produces a full WARN plus 4 closing steps.
